// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_ctrl_pkg
// Description : Shared encodings for the RV32I multi-cycle control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    localparam logic [3:0] c_alu_add  = 4'b0000;
    localparam logic [3:0] c_alu_sub  = 4'b0001;
    localparam logic [3:0] c_alu_and  = 4'b0010;
    localparam logic [3:0] c_alu_or   = 4'b0011;
    localparam logic [3:0] c_alu_xor  = 4'b0100;
    localparam logic [3:0] c_alu_sll  = 4'b0101;
    localparam logic [3:0] c_alu_srl  = 4'b0110;
    localparam logic [3:0] c_alu_sra  = 4'b0111;
    localparam logic [3:0] c_alu_slt  = 4'b1000;
    localparam logic [3:0] c_alu_sltu = 4'b1001;

    localparam logic [2:0] c_st_fetch  = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_exec   = 3'd2;
    localparam logic [2:0] c_st_mem    = 3'd3;
    localparam logic [2:0] c_st_wb     = 3'd4;
    localparam logic [2:0] c_st_trap   = 3'd5;

    localparam logic [1:0] c_pc_plus4  = 2'd0;
    localparam logic [1:0] c_pc_target = 2'd1;
    localparam logic [1:0] c_pc_alu    = 2'd2;

    localparam logic [1:0] c_wb_alu    = 2'd0;
    localparam logic [1:0] c_wb_mem    = 2'd1;
    localparam logic [1:0] c_wb_pc4    = 2'd2;

    localparam logic [1:0] c_a_rs1     = 2'd0;
    localparam logic [1:0] c_a_pc      = 2'd1;
    localparam logic [1:0] c_a_zero    = 2'd2;
    localparam logic [1:0] c_b_rs2     = 2'd0;
    localparam logic [1:0] c_b_imm     = 2'd1;

    typedef enum logic [1:0] {
        ALU_CLS_ADD    = 2'd0,
        ALU_CLS_R      = 2'd1,
        ALU_CLS_I      = 2'd2,
        ALU_CLS_BRANCH = 2'd3
    } alu_class_e;

    function automatic logic is_supported(input logic [6:0] op);
        case (op)
            c_op_r, c_op_i, c_op_load, c_op_store, c_op_branch,
            c_op_jal, c_op_jalr, c_op_lui, c_op_auipc: is_supported = 1'b1;
            default:                                   is_supported = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm_if
// Description : Variable-latency memory handshake shared by fetch and load/store.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_fsm_if;
    logic mem_req;
    logic mem_is_instr;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_is_instr, output mem_we, input  mem_ready);
    modport slave  (input  mem_req, input  mem_is_instr, input  mem_we, output mem_ready);
endinterface
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps instruction class and funct fields to the ALU operation.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  alu_class_e i_class,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic [3:0] o_alu_control
);

    always_comb begin
        o_alu_control = c_alu_add;
        case (i_class)
            ALU_CLS_R, ALU_CLS_I: begin
                case (i_funct3)
                    // Immediate bit 30 is just data for ADDI, so only R-type may select SUB.
                    3'b000:  o_alu_control = (i_class == ALU_CLS_R && i_funct7_5) ? c_alu_sub : c_alu_add;
                    3'b001:  o_alu_control = c_alu_sll;
                    3'b010:  o_alu_control = c_alu_slt;
                    3'b011:  o_alu_control = c_alu_sltu;
                    3'b100:  o_alu_control = c_alu_xor;
                    3'b101:  o_alu_control = i_funct7_5 ? c_alu_sra : c_alu_srl;
                    3'b110:  o_alu_control = c_alu_or;
                    default: o_alu_control = c_alu_and;
                endcase
            end
            ALU_CLS_BRANCH: begin
                case (i_funct3[2:1])
                    2'b10:   o_alu_control = c_alu_slt;
                    2'b11:   o_alu_control = c_alu_sltu;
                    default: o_alu_control = c_alu_sub;
                endcase
            end
            default: o_alu_control = c_alu_add;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  alu_zero,
    input  logic                  alu_lsb,
    multicycle_control_fsm_if.master mem,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic [1:0]            pc_src,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [3:0]            alu_control,
    output logic [1:0]            wb_sel,
    output logic [2:0]            state,
    output logic                  illegal,
    output logic                  bus_error,
    output logic                  retire,
    output logic [CNT_W-1:0]      instret
);

    localparam int WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

    logic [2:0]        r_state;
    logic              r_illegal;
    logic              r_bus_error;
    logic [CNT_W-1:0]  r_instret;
    logic [WAIT_W-1:0] r_wait;

    logic [2:0]  w_next;
    logic        w_mem_req, w_mem_is_instr, w_mem_we;
    logic        w_set_illegal, w_set_bus_error;
    logic        w_timeout, w_taken, w_branch_ok;
    logic [1:0]  w_a, w_b;
    logic [3:0]  w_alu;
    alu_class_e  w_class;

    always_comb begin
        case (opcode)
            c_op_r:      w_class = ALU_CLS_R;
            c_op_i:      w_class = ALU_CLS_I;
            c_op_branch: w_class = ALU_CLS_BRANCH;
            default:     w_class = ALU_CLS_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_class       (w_class),
        .i_funct3      (funct3),
        .i_funct7_5    (funct7_5),
        .o_alu_control (w_alu)
    );

    // Operand selections stay stable from EXEC through WB since the ALU result is not registered.
    always_comb begin
        w_a = c_a_rs1;
        w_b = c_b_rs2;
        case (opcode)
            c_op_i, c_op_load, c_op_store, c_op_jalr: w_b = c_b_imm;
            c_op_lui:   begin w_a = c_a_zero; w_b = c_b_imm; end
            c_op_auipc: begin w_a = c_a_pc;   w_b = c_b_imm; end
            default:    ;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:         w_taken = alu_zero;
            3'b001:         w_taken = !alu_zero;
            3'b100, 3'b110: w_taken = alu_lsb;
            3'b101, 3'b111: w_taken = !alu_lsb;
            default:        w_taken = 1'b0;
        endcase
    end

    assign w_branch_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
    assign w_timeout   = (r_wait == WAIT_W'(WAIT_LIMIT)) && !mem.mem_ready;

    always_comb begin
        w_next          = r_state;
        w_mem_req       = 1'b0;
        w_mem_is_instr  = 1'b0;
        w_mem_we        = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        pc_src          = c_pc_plus4;
        reg_write       = 1'b0;
        alu_src_a       = c_a_rs1;
        alu_src_b       = c_b_rs2;
        alu_control     = c_alu_add;
        wb_sel          = c_wb_alu;
        retire          = 1'b0;
        w_set_illegal   = 1'b0;
        w_set_bus_error = 1'b0;
        if (reset) begin
            if (r_state == c_st_exec || r_state == c_st_mem || r_state == c_st_wb) begin
                alu_src_a   = w_a;
                alu_src_b   = w_b;
                alu_control = w_alu;
            end
            case (r_state)
                c_st_fetch: begin
                    w_mem_req      = 1'b1;
                    w_mem_is_instr = 1'b1;
                    if (mem.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        w_next   = c_st_decode;
                    end else if (w_timeout) begin
                        w_set_bus_error = 1'b1;
                        w_next          = c_st_trap;
                    end
                end
                c_st_decode: begin
                    w_set_illegal = !is_supported(opcode);
                    w_next        = is_supported(opcode) ? c_st_exec : c_st_trap;
                end
                c_st_exec: begin
                    case (opcode)
                        c_op_load, c_op_store: w_next = c_st_mem;
                        c_op_branch: begin
                            if (w_branch_ok) begin
                                pc_write = w_taken;
                                pc_src   = w_taken ? c_pc_target : c_pc_plus4;
                                retire   = 1'b1;
                                w_next   = c_st_fetch;
                            end else begin
                                w_set_illegal = 1'b1;
                                w_next        = c_st_trap;
                            end
                        end
                        c_op_jal:  begin pc_write = 1'b1; pc_src = c_pc_target; w_next = c_st_wb; end
                        c_op_jalr: begin pc_write = 1'b1; pc_src = c_pc_alu;    w_next = c_st_wb; end
                        default:   w_next = c_st_wb;
                    endcase
                end
                c_st_mem: begin
                    w_mem_req = 1'b1;
                    w_mem_we  = (opcode == c_op_store);
                    if (mem.mem_ready) begin
                        retire = (opcode == c_op_store);
                        w_next = (opcode == c_op_store) ? c_st_fetch : c_st_wb;
                    end else if (w_timeout) begin
                        w_set_bus_error = 1'b1;
                        w_next          = c_st_trap;
                    end
                end
                c_st_wb: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    case (opcode)
                        c_op_load:           wb_sel = c_wb_mem;
                        c_op_jal, c_op_jalr: wb_sel = c_wb_pc4;
                        default:             wb_sel = c_wb_alu;
                    endcase
                    w_next = c_st_fetch;
                end
                c_st_trap: w_next = c_st_trap;
                default:   w_next = c_st_fetch;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= c_st_fetch;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
            r_instret   <= '0;
            r_wait      <= '0;
        end else begin
            r_state <= w_next;
            if (w_set_illegal)   r_illegal   <= 1'b1;
            if (w_set_bus_error) r_bus_error <= 1'b1;
            if (retire)          r_instret   <= r_instret + CNT_W'(1);
            // Any cycle without an outstanding wait, including leaving FETCH/MEM, restarts the count.
            if (w_mem_req && !mem.mem_ready) r_wait <= r_wait + WAIT_W'(1);
            else                             r_wait <= '0;
        end
    end

    assign mem.mem_req      = w_mem_req;
    assign mem.mem_is_instr = w_mem_is_instr;
    assign mem.mem_we       = w_mem_we;
    assign state            = r_state;
    assign illegal          = r_illegal;
    assign bus_error        = r_bus_error;
    assign instret          = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_fsm
// Description : Directed self-checking bench for the multi-cycle control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       alu_zero;
    logic       alu_lsb;
    logic       ir_write, pc_write, reg_write, retire, illegal, bus_error;
    logic [1:0] pc_src, alu_src_a, alu_src_b, wb_sel;
    logic [3:0] alu_control;
    logic [2:0] state;
    logic [3:0] instret;
    logic [18:0] vec;
    int n_total = 0;
    int n_bad   = 0;

    multicycle_control_fsm_if mif ();

    multicycle_control_fsm #(.WAIT_LIMIT(4), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .alu_zero(alu_zero), .alu_lsb(alu_lsb), .mem(mif.master), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .wb_sel(wb_sel), .state(state),
        .illegal(illegal), .bus_error(bus_error), .retire(retire), .instret(instret)
    );

    always #5 clock = ~clock;

    assign vec = {mif.mem_req, mif.mem_is_instr, mif.mem_we, ir_write, pc_write, pc_src,
                  reg_write, alu_src_a, alu_src_b, alu_control, wb_sel, retire};

    function automatic logic [18:0] v(input logic mr, input logic mi, input logic we,
                                      input logic irw, input logic pcw, input logic [1:0] pcs,
                                      input logic rw, input logic [1:0] a, input logic [1:0] b,
                                      input logic [3:0] alu, input logic [1:0] wb, input logic ret);
        return {mr, mi, we, irw, pcw, pcs, rw, a, b, alu, wb, ret};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input string tag, input logic [2:0] est, input logic [18:0] ev);
        #1;
        chk({tag, ".st"}, {29'd0, state}, {29'd0, est});
        chk({tag, ".sig"}, {13'd0, vec}, {13'd0, ev});
        tick();
    endtask

    task automatic set_instr(input logic [31:0] w);
        opcode   = w[6:0];
        funct3   = w[14:12];
        funct7_5 = w[30];
    endtask

    // FETCH with zero wait followed by the silent DECODE cycle.
    task automatic front(input string tag, input logic [31:0] w);
        set_instr(w);
        mif.mem_ready = 1'b1;
        step({tag, ".f"}, 3'd0, v(1,1,0,1,1,2'd0,0,2'd0,2'd0,4'd0,2'd0,0));
        step({tag, ".d"}, 3'd1, 19'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; mif.mem_ready = 1'b0; alu_zero = 1'b0; alu_lsb = 1'b0;
        set_instr(32'h0);
        #1;
        chk("rst_gate", {13'd0, vec}, 32'd0);
        tick(); tick();
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_cnt", {28'd0, instret}, 32'd0);
        chk("rst_flags", {30'd0, illegal, bus_error}, 32'd0);
        reset = 1'b1;

        front("addi", 32'h00a00093);
        step("addi.e", 3'd2, v(0,0,0,0,0,2'd0,0,2'd0,2'd1,4'd0,2'd0,0));
        step("addi.w", 3'd4, v(0,0,0,0,0,2'd0,1,2'd0,2'd1,4'd0,2'd0,1));
        chk("addi.cnt", {28'd0, instret}, 32'd1);

        front("sub", 32'h40208233);
        step("sub.e", 3'd2, v(0,0,0,0,0,2'd0,0,2'd0,2'd0,4'd1,2'd0,0));
        step("sub.w", 3'd4, v(0,0,0,0,0,2'd0,1,2'd0,2'd0,4'd1,2'd0,1));

        front("srai", 32'h4030d093);
        step("srai.e", 3'd2, v(0,0,0,0,0,2'd0,0,2'd0,2'd1,4'd7,2'd0,0));
        step("srai.w", 3'd4, v(0,0,0,0,0,2'd0,1,2'd0,2'd1,4'd7,2'd0,1));

        front("addin", 32'hc0000093);
        step("addin.e", 3'd2, v(0,0,0,0,0,2'd0,0,2'd0,2'd1,4'd0,2'd0,0));
        step("addin.w", 3'd4, v(0,0,0,0,0,2'd0,1,2'd0,2'd1,4'd0,2'd0,1));

        front("srl", 32'h0020d233);
        step("srl.e", 3'd2, v(0,0,0,0,0,2'd0,0,2'd0,2'd0,4'd6,2'd0,0));
        step("srl.w", 3'd4, v(0,0,0,0,0,2'd0,1,2'd0,2'd0,4'd6,2'd0,1));

        alu_zero = 1'b1;
        front("beq_t", 32'h00208463);
        step("beq_t.e", 3'd2, v(0,0,0,0,1,2'd1,0,2'd0,2'd0,4'd1,2'd0,1));
        alu_zero = 1'b0;
        front("beq_n", 32'h00208463);
        step("beq_n.e", 3'd2, v(0,0,0,0,0,2'd0,0,2'd0,2'd0,4'd1,2'd0,1));
        alu_lsb = 1'b1;
        front("blt", 32'h0020c463);
        step("blt.e", 3'd2, v(0,0,0,0,1,2'd1,0,2'd0,2'd0,4'd8,2'd0,1));
        front("bgeu", 32'h0020f463);
        step("bgeu.e", 3'd2, v(0,0,0,0,0,2'd0,0,2'd0,2'd0,4'd9,2'd0,1));
        alu_lsb = 1'b0;

        front("lw", 32'h0000a283);
        step("lw.e", 3'd2, v(0,0,0,0,0,2'd0,0,2'd0,2'd1,4'd0,2'd0,0));
        mif.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            step("lw.mw", 3'd3, v(1,0,0,0,0,2'd0,0,2'd0,2'd1,4'd0,2'd0,0));
        mif.mem_ready = 1'b1;
        step("lw.m", 3'd3, v(1,0,0,0,0,2'd0,0,2'd0,2'd1,4'd0,2'd0,0));
        step("lw.w", 3'd4, v(0,0,0,0,0,2'd0,1,2'd0,2'd1,4'd0,2'd1,1));

        front("sw", 32'h0050a023);
        step("sw.e", 3'd2, v(0,0,0,0,0,2'd0,0,2'd0,2'd1,4'd0,2'd0,0));
        step("sw.m", 3'd3, v(1,0,1,0,0,2'd0,0,2'd0,2'd1,4'd0,2'd0,1));

        front("jal", 32'h010000ef);
        step("jal.e", 3'd2, v(0,0,0,0,1,2'd1,0,2'd0,2'd0,4'd0,2'd0,0));
        step("jal.w", 3'd4, v(0,0,0,0,0,2'd0,1,2'd0,2'd0,4'd0,2'd2,1));

        front("jalr", 32'h000100e7);
        step("jalr.e", 3'd2, v(0,0,0,0,1,2'd2,0,2'd0,2'd1,4'd0,2'd0,0));
        step("jalr.w", 3'd4, v(0,0,0,0,0,2'd0,1,2'd0,2'd1,4'd0,2'd2,1));

        front("lui", 32'h000010b7);
        step("lui.e", 3'd2, v(0,0,0,0,0,2'd0,0,2'd2,2'd1,4'd0,2'd0,0));
        step("lui.w", 3'd4, v(0,0,0,0,0,2'd0,1,2'd2,2'd1,4'd0,2'd0,1));

        front("auipc", 32'h00001097);
        step("auipc.e", 3'd2, v(0,0,0,0,0,2'd0,0,2'd1,2'd1,4'd0,2'd0,0));
        step("auipc.w", 3'd4, v(0,0,0,0,0,2'd0,1,2'd1,2'd1,4'd0,2'd0,1));
        chk("cnt15", {28'd0, instret}, 32'd15);

        front("wrap", 32'h00a00093);
        step("wrap.e", 3'd2, v(0,0,0,0,0,2'd0,0,2'd0,2'd1,4'd0,2'd0,0));
        step("wrap.w", 3'd4, v(0,0,0,0,0,2'd0,1,2'd0,2'd1,4'd0,2'd0,1));
        chk("cnt_wrap", {28'd0, instret}, 32'd0);

        front("badbr", 32'h0020a463);
        step("badbr.e", 3'd2, v(0,0,0,0,0,2'd0,0,2'd0,2'd0,4'd1,2'd0,0));
        #1;
        chk("badbr.trap", {29'd0, state}, 32'd5);
        chk("badbr.ill", {31'd0, illegal}, 32'd1);
        pulse_reset();

        front("illop", 32'h00000000);
        for (int i = 0; i < 20; i++) step("illop.t", 3'd5, 19'd0);
        chk("illop.ill", {31'd0, illegal}, 32'd1);
        chk("illop.cnt", {28'd0, instret}, 32'd0);
        pulse_reset();
        #1;
        chk("illop.clr_st", {29'd0, state}, 32'd0);
        chk("illop.clr", {31'd0, illegal}, 32'd0);

        mif.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            step("tmo.f", 3'd0, v(1,1,0,0,0,2'd0,0,2'd0,2'd0,4'd0,2'd0,0));
        chk("tmo.berr", {30'd0, illegal, bus_error}, 32'd1);
        mif.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) step("tmo.t", 3'd5, 19'd0);
        pulse_reset();
        #1;
        chk("tmo.clr", {31'd0, bus_error}, 32'd0);

        front("pre", 32'h00a00093);
        tick(); tick();
        chk("pre.cnt", {28'd0, instret}, 32'd1);
        front("swr", 32'h0050a023);
        step("swr.e", 3'd2, v(0,0,0,0,0,2'd0,0,2'd0,2'd1,4'd0,2'd0,0));
        mif.mem_ready = 1'b0;
        step("swr.m", 3'd3, v(1,0,1,0,0,2'd0,0,2'd0,2'd1,4'd0,2'd0,0));
        reset = 1'b0;
        #1;
        chk("swr.drop", {13'd0, vec}, 32'd0);
        tick();
        reset = 1'b1;
        chk("swr.cnt", {28'd0, instret}, 32'd0);
        step("swr.f", 3'd0, v(1,1,0,0,0,2'd0,0,2'd0,2'd0,4'd0,2'd0,0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle control unit that sequences the existing RV32I datapath (instruction memory, register file, ALU, write-back mux) through the FETCH/DECODE/EXEC/MEM/WB phases.
- Replaces the single-cycle combinational control.
- Handles a variable-latency memory handshake shared by fetch and load/store, and counts retired instructions.
- Traps on illegal opcodes and memory timeouts.

Parameters:
- WAIT_LIMIT, 255: maximum cycles a memory request may wait for mem_ready before bus_error.
- CNT_W, 32: width of the instret counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low
- opcode  in  7  instruction[6:0] from the instruction register
- funct3  in  3  instruction[14:12]
- funct7_5  in  1  instruction[30]
- alu_zero  in  1  ALU result == 0
- alu_lsb  in  1  ALU result bit 0 (SLT/SLTU outcome)
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_is_instr  out  1  1 = fetch address (PC), 0 = data address (ALU)
- mem_we  out  1  store
- ir_write  out  1  latch instruction and old PC
- pc_write  out  1  update PC
- pc_src  out  2  0 = PC+4, 1 = old_PC+imm, 2 = ALU result with bit 0 cleared
- reg_write  out  1  register file write enable
- alu_src_a  out  2  0 = rs1, 1 = old_PC, 2 = zero
- alu_src_b  out  2  0 = rs2, 1 = imm
- alu_control  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = old_PC+4
- state  out  3  current state, for debug/testbench
- illegal  out  1  sticky illegal-instruction flag
- bus_error  out  1  sticky memory-timeout flag
- retire  out  1  one-cycle pulse on the last cycle of each instruction
- instret  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Registered state; strobes are combinational from state and inputs.
- Reset:
  - While reset=0, all strobes are forced to 0.
  - On a clock edge with reset=0: state=FETCH, illegal=0, bus_error=0, instret=0, wait counter=0.
  - Reset mid-instruction abandons it; no write occurs in the reset cycle.
- FETCH:
  - mem_req=1, mem_is_instr=1.
  - Hold until mem_ready. In the mem_ready cycle: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
  - Zero-wait (mem_ready in the first cycle) is legal.
- DECODE: one cycle, no strobes; register file read. Next state EXEC, or TRAP if the opcode is not in the supported set.
- EXEC, by opcode:
  - 0110011 R-type: a=rs1, b=rs2, ALU op from funct3 and funct7_5 (funct7_5 selects SUB/SRA). Next WB.
  - 0010011 I-type: b=imm, same decode except funct7_5 is used only for shift-right. Next WB.
  - 0000011 LOAD / 0100011 STORE: ADD, b=imm. Next MEM.
  - 1100011 BRANCH:
    - a=rs1, b=rs2; ALU is SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
    - Taken when: BEQ alu_zero, BNE !alu_zero, BLT alu_lsb, BGE !alu_lsb, BLTU alu_lsb, BGEU !alu_lsb.
    - If taken: pc_write=1, pc_src=1.
    - funct3 010/011 → TRAP. Otherwise retire=1, next FETCH.
  - 1101111 JAL: pc_write=1, pc_src=1. Next WB with wb_sel=2.
  - 1100111 JALR: ADD, a=rs1, b=imm, pc_write=1, pc_src=2. Next WB with wb_sel=2.
  - 0110111 LUI: a=zero, b=imm, ADD. Next WB.
  - 0010111 AUIPC: a=old_PC, b=imm, ADD. Next WB.
- MEM:
  - mem_req=1, mem_is_instr=0, mem_we=1 for STORE. ALU inputs are held at the EXEC selections.
  - Hold until mem_ready. Then LOAD → WB (wb_sel=1); STORE → retire=1, FETCH.
- WB: reg_write=1, wb_sel per instruction class, retire=1. Next FETCH.
- instret increments on every retire. It wraps at 2^CNT_W.
- Wait counter:
  - Clears on entering FETCH or MEM, and on mem_ready.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - When it reaches WAIT_LIMIT and mem_ready=0: bus_error=1, next TRAP, no ir_write or reg_write.
- TRAP: all strobes 0; illegal or bus_error held; exits only on reset.
- Latencies with zero-wait memory: R/I/LUI/AUIPC/JAL/JALR 4 cycles, LOAD 5, STORE 4, BRANCH 3.
- x0 write protection remains in the register file, not here.

Decomposition:
- Shared package rv_ctrl_pkg: opcode constants, ALU code constants, state encoding, pc_src/wb_sel/alu_src encodings.
- One natural sub-module, alu_decoder: combinational (class, funct3, funct7_5) → alu_control.

Test Plan:
- 00a00093 (ADDI x1,x0,10), mem_ready=1 throughout → state sequence 0,1,2,4,0; alu_src_b=1, alu_control=0000 in EXEC; reg_write=1 and retire=1 in cycle 4; instret=1.
- 40208233 (SUB x4,x1,x2) → EXEC alu_control=0001, alu_src_b=0; reg_write in WB with wb_sel=0.
- BEQ with alu_zero=1 → EXEC pc_write=1, pc_src=1, retire=1, 3 cycles total. Repeat with alu_zero=0 → pc_write=0.
- LW with mem_ready low for 3 MEM cycles → MEM lasts 4 cycles, mem_we=0, then WB with wb_sel=1; total 8 cycles.
- Opcode 0000000 → DECODE goes to TRAP, illegal=1; 20 further cycles with all strobes 0; reset=0 for one edge → FETCH, illegal=0.
- WAIT_LIMIT=4 with mem_ready held 0 in FETCH → bus_error=1 after the 5th cycle, TRAP, ir_write never asserted.
- Reset asserted in MEM of a store → mem_req/mem_we drop immediately, FETCH on the next cycle, instret=0.
